// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if: decode/writeback port bundle of the register file with scoreboard.
interface regfile_scoreboard_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
);
  logic             WE_RF;
  logic [AW-1:0]    RW_RF;
  logic [XLEN-1:0]  DW_RF;
  logic [AW-1:0]    RA_RF;
  logic [AW-1:0]    RB_RF;
  logic [XLEN-1:0]  A_RF;
  logic [XLEN-1:0]  B_RF;
  logic             ISSUE_RF;
  logic [AW-1:0]    RD_ISSUE_RF;
  logic             BUSY_A_RF;
  logic             BUSY_B_RF;
  logic [NREGS-1:0] BUSY_VEC_RF;
  modport master (
    output WE_RF, RW_RF, DW_RF, RA_RF, RB_RF, ISSUE_RF, RD_ISSUE_RF,
    input  A_RF, B_RF, BUSY_A_RF, BUSY_B_RF, BUSY_VEC_RF
  );
  modport slave (
    input  WE_RF, RW_RF, DW_RF, RA_RF, RB_RF, ISSUE_RF, RD_ISSUE_RF,
    output A_RF, B_RF, BUSY_A_RF, BUSY_B_RF, BUSY_VEC_RF
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 2R/1W register file with optional zero register, write bypass and RAW busy scoreboard.
module regfile_scoreboard #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int AW       = 5,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input logic CLK,
  input logic RES,
  regfile_scoreboard_if.slave rf
);
  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy, busy_next;
  logic             zero_w, byp_a, byp_b, zero_a, zero_b;
  assign zero_w = (ZERO_REG != 0) && rf.RW_RF == '0;
  // A new issue outranks a same-cycle writeback: the register has a fresh producer pending.
  always_comb begin
    busy_next = busy;
    for (int i = 0; i < NREGS; i++)
      busy_next[i] = (rf.ISSUE_RF && rf.RD_ISSUE_RF == AW'(i) && !((ZERO_REG != 0) && i == 0)) ? 1'b1 :
                     (rf.WE_RF && rf.RW_RF == AW'(i)) ? 1'b0 : busy[i];
  end
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      if (rf.WE_RF && !zero_w) regs[rf.RW_RF] <= rf.DW_RF;
      busy <= busy_next;
    end
  end
  assign byp_a  = (BYPASS != 0) && rf.WE_RF && rf.RW_RF == rf.RA_RF;
  assign byp_b  = (BYPASS != 0) && rf.WE_RF && rf.RW_RF == rf.RB_RF;
  assign zero_a = (ZERO_REG != 0) && rf.RA_RF == '0;
  assign zero_b = (ZERO_REG != 0) && rf.RB_RF == '0;
  // Reset must also suppress the bypass path, which would otherwise leak DW_RF.
  assign rf.A_RF        = (RES || zero_a) ? '0 : byp_a ? rf.DW_RF : regs[rf.RA_RF];
  assign rf.B_RF        = (RES || zero_b) ? '0 : byp_b ? rf.DW_RF : regs[rf.RB_RF];
  assign rf.BUSY_A_RF   = busy[rf.RA_RF] && !byp_a && !zero_a;
  assign rf.BUSY_B_RF   = busy[rf.RB_RF] && !byp_b && !zero_b;
  assign rf.BUSY_VEC_RF = busy;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed checks of read/write, bypass, zero register, scoreboard and async reset.
module tb_regfile_scoreboard;
  logic CLK, RES;
  int   pass_cnt, total_cnt;
  regfile_scoreboard_if #(.XLEN(32), .NREGS(32), .AW(5)) bus ();
  regfile_scoreboard_if #(.XLEN(32), .NREGS(32), .AW(5)) nb ();
  regfile_scoreboard #(.BYPASS(1), .ZERO_REG(1)) dut (.CLK(CLK), .RES(RES), .rf(bus));
  regfile_scoreboard #(.BYPASS(0), .ZERO_REG(0)) dut_nb (.CLK(CLK), .RES(RES), .rf(nb));
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  task automatic idle();
    bus.WE_RF = 0; bus.RW_RF = 0; bus.DW_RF = 0; bus.RA_RF = 0; bus.RB_RF = 0;
    bus.ISSUE_RF = 0; bus.RD_ISSUE_RF = 0;
    nb.WE_RF = 0; nb.RW_RF = 0; nb.DW_RF = 0; nb.RA_RF = 0; nb.RB_RF = 0;
    nb.ISSUE_RF = 0; nb.RD_ISSUE_RF = 0;
  endtask
  task automatic test_reset();
    RES = 1; idle();
    bus.WE_RF = 1; bus.RW_RF = 6; bus.DW_RF = 32'h55; bus.RA_RF = 6; bus.RB_RF = 6;
    @(negedge CLK); #1;
    total_cnt++; if (bus.A_RF !== 32'h0) $display("FAIL reset_a: got %h want 0", bus.A_RF); else pass_cnt++;
    total_cnt++; if (bus.B_RF !== 32'h0) $display("FAIL reset_b: got %h want 0", bus.B_RF); else pass_cnt++;
    total_cnt++; if (bus.BUSY_VEC_RF !== 32'h0) $display("FAIL reset_vec: got %h want 0", bus.BUSY_VEC_RF); else pass_cnt++;
    total_cnt++; if (bus.BUSY_A_RF !== 1'b0) $display("FAIL reset_busy_a: got %b want 0", bus.BUSY_A_RF); else pass_cnt++;
    idle(); RES = 0;
    @(negedge CLK); #1;
    total_cnt++; if (bus.A_RF !== 32'h0) $display("FAIL reset_nowrite: got %h want 0", bus.A_RF); else pass_cnt++;
  endtask
  task automatic test_write_read();
    @(negedge CLK); bus.WE_RF = 1; bus.RW_RF = 5; bus.DW_RF = 32'hDEADBEEF;
    @(negedge CLK); idle(); bus.RA_RF = 5; bus.RB_RF = 5; #1;
    total_cnt++; if (bus.A_RF !== 32'hDEADBEEF) $display("FAIL wr_rd_a: got %h want deadbeef", bus.A_RF); else pass_cnt++;
    total_cnt++; if (bus.B_RF !== 32'hDEADBEEF) $display("FAIL wr_rd_b: got %h want deadbeef", bus.B_RF); else pass_cnt++;
    total_cnt++; if (bus.BUSY_A_RF !== 1'b0) $display("FAIL wr_rd_busy_a: got %b want 0", bus.BUSY_A_RF); else pass_cnt++;
  endtask
  task automatic test_bypass();
    @(negedge CLK);
    bus.WE_RF = 1; bus.RW_RF = 7; bus.DW_RF = 32'h12345678; bus.RA_RF = 7; bus.RB_RF = 7;
    nb.WE_RF = 1; nb.RW_RF = 7; nb.DW_RF = 32'h12345678; nb.RA_RF = 7; nb.RB_RF = 7;
    #1;
    total_cnt++; if (bus.A_RF !== 32'h12345678) $display("FAIL byp_a: got %h want 12345678", bus.A_RF); else pass_cnt++;
    total_cnt++; if (bus.B_RF !== 32'h12345678) $display("FAIL byp_b: got %h want 12345678", bus.B_RF); else pass_cnt++;
    total_cnt++; if (nb.A_RF !== 32'h0) $display("FAIL nobyp_a: got %h want 0", nb.A_RF); else pass_cnt++;
    total_cnt++; if (nb.B_RF !== 32'h0) $display("FAIL nobyp_b: got %h want 0", nb.B_RF); else pass_cnt++;
    @(negedge CLK); idle(); nb.RA_RF = 7; #1;
    total_cnt++; if (nb.A_RF !== 32'h12345678) $display("FAIL nobyp_after: got %h want 12345678", nb.A_RF); else pass_cnt++;
  endtask
  task automatic test_zero_reg();
    @(negedge CLK);
    bus.WE_RF = 1; bus.RW_RF = 0; bus.DW_RF = 32'hFFFFFFFF; bus.ISSUE_RF = 1; bus.RD_ISSUE_RF = 0;
    nb.WE_RF = 1; nb.RW_RF = 0; nb.DW_RF = 32'hCAFE0000;
    #1;
    total_cnt++; if (bus.A_RF !== 32'h0) $display("FAIL zero_a_same: got %h want 0", bus.A_RF); else pass_cnt++;
    @(negedge CLK); idle(); #1;
    total_cnt++; if (bus.A_RF !== 32'h0) $display("FAIL zero_a: got %h want 0", bus.A_RF); else pass_cnt++;
    total_cnt++; if (bus.BUSY_A_RF !== 1'b0) $display("FAIL zero_busy_a: got %b want 0", bus.BUSY_A_RF); else pass_cnt++;
    total_cnt++; if (bus.BUSY_VEC_RF[0] !== 1'b0) $display("FAIL zero_vec0: got %b want 0", bus.BUSY_VEC_RF[0]); else pass_cnt++;
    total_cnt++; if (nb.A_RF !== 32'hCAFE0000) $display("FAIL nozero_r0: got %h want cafe0000", nb.A_RF); else pass_cnt++;
  endtask
  task automatic test_scoreboard();
    @(negedge CLK); bus.ISSUE_RF = 1; bus.RD_ISSUE_RF = 3;
    @(negedge CLK); idle(); bus.RA_RF = 3; bus.RB_RF = 4; #1;
    total_cnt++; if (bus.BUSY_VEC_RF !== 32'h8) $display("FAIL sb_vec_set: got %h want 00000008", bus.BUSY_VEC_RF); else pass_cnt++;
    total_cnt++; if (bus.BUSY_A_RF !== 1'b1) $display("FAIL sb_busy_a: got %b want 1", bus.BUSY_A_RF); else pass_cnt++;
    total_cnt++; if (bus.BUSY_B_RF !== 1'b0) $display("FAIL sb_busy_b: got %b want 0", bus.BUSY_B_RF); else pass_cnt++;
    @(negedge CLK); bus.WE_RF = 1; bus.RW_RF = 3; bus.DW_RF = 32'hA5; #1;
    total_cnt++; if (bus.BUSY_A_RF !== 1'b0) $display("FAIL sb_busy_a_byp: got %b want 0", bus.BUSY_A_RF); else pass_cnt++;
    total_cnt++; if (bus.BUSY_VEC_RF !== 32'h8) $display("FAIL sb_vec_hold: got %h want 00000008", bus.BUSY_VEC_RF); else pass_cnt++;
    @(negedge CLK); idle(); bus.RA_RF = 3; #1;
    total_cnt++; if (bus.BUSY_VEC_RF !== 32'h0) $display("FAIL sb_vec_clr: got %h want 0", bus.BUSY_VEC_RF); else pass_cnt++;
    total_cnt++; if (bus.A_RF !== 32'hA5) $display("FAIL sb_data: got %h want 000000a5", bus.A_RF); else pass_cnt++;
  endtask
  task automatic test_back_to_back();
    @(negedge CLK); bus.ISSUE_RF = 1; bus.RD_ISSUE_RF = 9; bus.WE_RF = 1; bus.RW_RF = 9; bus.DW_RF = 32'h1;
    @(negedge CLK); idle(); bus.RA_RF = 9; #1;
    total_cnt++; if (bus.A_RF !== 32'h1) $display("FAIL b2b_data: got %h want 1", bus.A_RF); else pass_cnt++;
    total_cnt++; if (bus.BUSY_VEC_RF !== 32'h200) $display("FAIL b2b_vec: got %h want 00000200", bus.BUSY_VEC_RF); else pass_cnt++;
    total_cnt++; if (bus.BUSY_A_RF !== 1'b1) $display("FAIL b2b_busy_a: got %b want 1", bus.BUSY_A_RF); else pass_cnt++;
  endtask
  task automatic test_async_reset();
    for (int i = 1; i <= 4; i++) begin
      @(negedge CLK);
      bus.WE_RF = 1; bus.RW_RF = 5'(i); bus.DW_RF = 32'(i * 32'h11);
      bus.ISSUE_RF = 1; bus.RD_ISSUE_RF = 5'(i);
    end
    @(negedge CLK); idle(); bus.RA_RF = 2; bus.RB_RF = 4; #1;
    total_cnt++; if (bus.BUSY_VEC_RF !== 32'h21E) $display("FAIL ar_vec_pre: got %h want 0000021e", bus.BUSY_VEC_RF); else pass_cnt++;
    total_cnt++; if (bus.B_RF !== 32'h44) $display("FAIL ar_b_pre: got %h want 00000044", bus.B_RF); else pass_cnt++;
    bus.WE_RF = 1; bus.RW_RF = 2; bus.DW_RF = 32'h77777777;
    #2 RES = 1; #1;
    total_cnt++; if (bus.A_RF !== 32'h0) $display("FAIL ar_a: got %h want 0", bus.A_RF); else pass_cnt++;
    total_cnt++; if (bus.B_RF !== 32'h0) $display("FAIL ar_b: got %h want 0", bus.B_RF); else pass_cnt++;
    total_cnt++; if (bus.BUSY_VEC_RF !== 32'h0) $display("FAIL ar_vec: got %h want 0", bus.BUSY_VEC_RF); else pass_cnt++;
    total_cnt++; if (bus.BUSY_B_RF !== 1'b0) $display("FAIL ar_busy_b: got %b want 0", bus.BUSY_B_RF); else pass_cnt++;
    @(posedge CLK); @(negedge CLK); #2 RES = 0; idle();
    for (int i = 1; i <= 4; i++) begin
      bus.RA_RF = 5'(i); bus.RB_RF = 5'(i); #1;
      total_cnt++; if (bus.A_RF !== 32'h0) $display("FAIL ar_post_a%0d: got %h want 0", i, bus.A_RF); else pass_cnt++;
    end
    @(negedge CLK); #1;
    total_cnt++; if (bus.BUSY_VEC_RF !== 32'h0) $display("FAIL ar_post_vec: got %h want 0", bus.BUSY_VEC_RF); else pass_cnt++;
  endtask
  initial begin
    pass_cnt = 0; total_cnt = 0;
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_scoreboard();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
